// File: rtl/falling_object_scheduler_pkg.sv
// Shared types and constants for the falling-object spawn scheduler.
package sched_pkg;

    localparam int unsigned SPEED_W = 8;
    localparam int unsigned COUNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Population count of up to 16 enable bits. The caller guarantees that
    // fewer than 16 bits are set, so the result always fits in COUNT_W bits.
    function automatic logic [COUNT_W-1:0] popcount16(input logic [15:0] v);
        logic [COUNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            c = c + COUNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/falling_object_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible index after
// ptr_i, wrapping modulo N. The caller owns and updates the pointer.
module rr_arbiter #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int unsigned   j;
    logic [IW-1:0] jj;
    logic          found;

    // Scan ptr_i+1 .. ptr_i+N (mod N) and keep the first eligible hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            j  = (32'(ptr_i) + off) % N;
            jj = IW'(j);
            if (!found && eligible_i[jj]) begin
                found       = 1'b1;
                valid_o     = 1'b1;
                idx_o       = jj;
                grant_o[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/falling_object_scheduler.sv
// Spawn controller for a bank of falling objects: round-robin enable grants
// with a concurrency cap, a minimum tick gap between grants, and a common
// fall speed. Optional speed ramp is compiled in with `define SPEED_RAMP_EN.
module falling_object_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NUM_OBJECTS   = 8,
    parameter int unsigned MIN_GAP_TICKS = 20,
    parameter int unsigned RAMP_TICKS    = 100,
    parameter int unsigned MAX_SPEED     = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_of_level,
    input  logic                   end_level,
    input  logic                   pause,
    input  logic                   one_tens_sec,
    input  logic [NUM_OBJECTS-1:0] req,
    input  logic [NUM_OBJECTS-1:0] visible,
    input  logic [NUM_OBJECTS-1:0] exceed,
    input  logic [COUNT_W-1:0]     max_active,
    input  logic [SPEED_W-1:0]     base_speed,
    output logic [NUM_OBJECTS-1:0] enable,
    output logic [SPEED_W-1:0]     object_speed,
    output logic [COUNT_W-1:0]     active_count,
    output logic                   drained
);

    localparam int unsigned IDX_W = $clog2(NUM_OBJECTS);
    localparam int unsigned GAP_W = (MIN_GAP_TICKS < 1) ? 1 : $clog2(MIN_GAP_TICKS + 1);

    sched_state_t             state_q, state_d;
    logic [NUM_OBJECTS-1:0]   enable_q, enable_d;
    logic [SPEED_W-1:0]       speed_q, speed_d;
    logic [COUNT_W-1:0]       active_q, active_d;
    logic                     drained_q, drained_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [15:0]              enable_ext;

`ifdef SPEED_RAMP_EN
    localparam int unsigned RAMP_W = (RAMP_TICKS < 2) ? 1 : $clog2(RAMP_TICKS);
    logic [RAMP_W-1:0]        ramp_q, ramp_d;
`else
    localparam int unsigned UNUSED_RAMP_CFG = RAMP_TICKS + MAX_SPEED;
`endif

    // An object that is already enabled or is leaving this cycle cannot win.
    logic [NUM_OBJECTS-1:0]   eligible;
    logic [NUM_OBJECTS-1:0]   arb_grant;
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_valid;

    assign eligible = req & ~enable_q & ~exceed;

    rr_arbiter #(
        .N  (NUM_OBJECTS),
        .IW (IDX_W)
    ) u_arb (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .grant_o    (arb_grant),
        .idx_o      (arb_idx),
        .valid_o    (arb_valid)
    );

    // Next-state logic: level FSM, grant/release, gap timer and speed.
    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q & ~exceed;
        speed_d    = speed_q;
        gap_d      = gap_q;
        rr_ptr_d   = rr_ptr_q;
        drained_d  = 1'b0;
        enable_ext = '0;
`ifdef SPEED_RAMP_EN
        ramp_d     = ramp_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_of_level && !end_level) begin
                    state_d = RUN;
                    speed_d = base_speed;
                    gap_d   = '0;
`ifdef SPEED_RAMP_EN
                    ramp_d  = '0;
`endif
                end
            end
            RUN: begin
                if (end_level) begin
                    state_d  = DRAIN;
                    enable_d = '0;
                end else if (!pause) begin
                    if (one_tens_sec && gap_q != '0) begin
                        gap_d = gap_q - 1'b1;
                    end
                    if (gap_q == '0 && active_q < max_active && arb_valid) begin
                        enable_d = enable_d | arb_grant;
                        rr_ptr_d = arb_idx;
                        gap_d    = GAP_W'(MIN_GAP_TICKS);
                    end
`ifdef SPEED_RAMP_EN
                    if (one_tens_sec) begin
                        if (ramp_q == RAMP_W'(RAMP_TICKS - 1)) begin
                            ramp_d = '0;
                            if (speed_q < SPEED_W'(MAX_SPEED)) begin
                                speed_d = speed_q + 1'b1;
                            end
                        end else begin
                            ramp_d = ramp_q + 1'b1;
                        end
                    end
`endif
                end
            end
            DRAIN: begin
                enable_d = '0;
                if (visible == '0) begin
                    drained_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                enable_d = '0;
            end
        endcase
        enable_ext[NUM_OBJECTS-1:0] = enable_d;
        active_d = popcount16(enable_ext);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            enable_q  <= '0;
            speed_q   <= '0;
            active_q  <= '0;
            drained_q <= 1'b0;
            gap_q     <= '0;
            rr_ptr_q  <= IDX_W'(NUM_OBJECTS - 1);
`ifdef SPEED_RAMP_EN
            ramp_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            speed_q   <= speed_d;
            active_q  <= active_d;
            drained_q <= drained_d;
            gap_q     <= gap_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef SPEED_RAMP_EN
            ramp_q    <= ramp_d;
`endif
        end
    end

    assign enable       = enable_q;
    assign object_speed = speed_q;
    assign active_count = active_q;
    assign drained      = drained_q;

endmodule

// File: doc/falling_object_scheduler.md
Name: falling_object_scheduler

Overview:
- Central spawn controller for a bank of NUM_OBJECTS falling-object FSMs.
- Each object signals it is ready to appear. The scheduler grants per-object enable permissions round-robin.
- It caps the number of objects moving at once, enforces a minimum spawn spacing, and supplies a common fall speed.
- It sits between the level controller (start/end of level) and the object instances.

Parameters:
- NUM_OBJECTS, 8, number of scheduled objects (2..16).
- MIN_GAP_TICKS, 20, minimum number of one_tens_sec ticks between consecutive grants.
- RAMP_TICKS, 100, ticks per speed increment (optional feature only).
- MAX_SPEED, 12, speed saturation value (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_of_level  in  1  pulse; arms scheduling
- end_level  in  1  pulse; revokes all grants
- pause  in  1  level: blocks new grants and freezes counters
- one_tens_sec  in  1  0.1 s tick, one clk wide
- req  in  NUM_OBJECTS  object i is waiting and its reappear timer has expired
- visible  in  NUM_OBJECTS  object i is on screen
- exceed  in  NUM_OBJECTS  pulse: object i has left the screen
- max_active  in  4  concurrency cap; 0 means no grants
- base_speed  in  8  speed at level start
- enable  out  NUM_OBJECTS  registered per-object permission
- object_speed  out  8  registered common speed
- active_count  out  4  popcount(enable)
- drained  out  1  one-cycle pulse when a level is fully cleared

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - enable=0, object_speed=0, active_count=0, drained=0.
  - State=IDLE, gap counter=0.
  - rr_ptr=NUM_OBJECTS-1, so the first search starts at index 0.
- States IDLE, RUN, DRAIN:
  - IDLE: start_of_level -> RUN. Latch object_speed<=base_speed and gap counter<=0.
  - RUN: end_level -> DRAIN and clear all enable bits in the same edge.
  - DRAIN: no grants. When visible==0, emit drained=1 for one cycle and go to IDLE.
- end_level has priority over start_of_level and over any grant. start_of_level outside IDLE is ignored.
- Grant condition, evaluated in RUN only:
  - not pause, gap==0, active_count<max_active;
  - some i exists with req[i]=1 and enable[i]=0.
- Grant selection:
  - At most one grant per cycle.
  - Winner is the first qualifying index scanning from rr_ptr+1 with wrap modulo NUM_OBJECTS.
  - On grant: enable[winner]<=1, rr_ptr<=winner, gap<=MIN_GAP_TICKS.
- Release: exceed[i] clears enable[i] next edge.
  - Clear wins over a grant to the same i in the same cycle; that object stays ineligible that cycle.
- req[i] while enable[i]=1 is ignored.
- Gap counter: decrements on one_tens_sec when >0, RUN, and not pause. It saturates at 0.
- active_count is recomputed from the next-state enable vector so it is coherent with enable.
- Lowering max_active below active_count revokes nothing. It only blocks new grants.
- pause leaves existing enable bits set, so moving objects continue.

Optional Feature:
- Macro SPEED_RAMP_EN.
- When defined:
  - A ramp counter is cleared at start_of_level.
  - It counts one_tens_sec ticks in RUN while not paused.
  - At RAMP_TICKS it wraps to 0 and object_speed increments, saturating at MAX_SPEED.
  - If base_speed>MAX_SPEED, the speed is held at base_speed.
- When undefined: object_speed stays at the latched base_speed for the whole level, and no ramp counter is built.

Decomposition:
- Shared package sched_pkg:
  - enum sched_state_t {IDLE, RUN, DRAIN};
  - localparam widths SPEED_W=8, COUNT_W=4.
- Sub-module rr_arbiter (parameter N):
  - inputs: eligible vector, pointer;
  - outputs: one-hot grant, index, valid;
  - purely combinational; the top holds rr_ptr.

Test Plan:
- Reset, then start_of_level with base_speed=5, max_active=3, req=8'b0000_0001 -> enable=8'b0000_0001 one cycle later; object_speed=5; no further grant for 20 ticks.
- req=8'hFF held, max_active=3 -> grants to indices 0, 1, 2, each exactly 20 ticks apart; active_count stops at 3. Then exceed[1] -> next grant after the gap goes to index 3.
- exceed[2] and a qualifying grant to index 2 in the same cycle -> enable[2]=0; index 2 is granted only on a later cycle.
- end_level while 3 objects are enabled and visible -> enable=0 on the next edge; drained pulses exactly once, one cycle after visible reaches 0; state returns to IDLE.
- pause asserted mid-gap with 5 ticks remaining, for 50 ticks -> no grants during pause; after release a grant occurs only after 5 further ticks; existing enable bits are unchanged.
- SPEED_RAMP_EN with RAMP_TICKS=100, base_speed=11, MAX_SPEED=12 -> speed is 12 after 100 ticks and stays 12 after 300 ticks.
